irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt aggregator on the device bus. Sits downstream of the timer and other peripherals and consumes their interrupt lines.
- Latches requests into pending bits, masks them with an enable register, and drives one registered external interrupt line to the core.
- Provides a claim register that returns and clears the highest-priority pending source.
- Uses the same one-cycle-response device bus protocol as the other peripherals.

Parameters:
- DataWidth, 32, bus data width (must be 32).
- AddressWidth, 32, bus address width.
- NumSrc, 8, number of interrupt sources (1..31).
- SrcEdge, 8'h00, per-source mode (NumSrc bits): 1 = rising-edge triggered, 0 = level.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- irq_req_i  input  1  bus request; upper address bits already decoded.
- irq_addr_i  input  AddressWidth  byte address; only [9:0] used.
- irq_we_i  input  1  write enable.
- irq_be_i  input  DataWidth/8  byte enables.
- irq_wdata_i  input  DataWidth  write data.
- irq_rvalid_o  output  1  response valid, one cycle after every request.
- irq_rdata_o  output  DataWidth  read data.
- irq_err_o  output  1  error response, valid with irq_rvalid_o.
- src_i  input  NumSrc  interrupt sources, synchronous to clk_i (e.g. timer interrupt on bit 0).
- irq_o  output  1  external interrupt to the core.

Behaviour:
- Clock and reset: one clock clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - pending, enable, src_q, irq_o, irq_rvalid_o: all 0.
  - irq_rdata_o and irq_err_o are not reset; they are meaningful only while irq_rvalid_o is high.
- Register map, offset in addr[9:0]:
  - 0x000 PENDING: read returns pending bits. Write is W1C: each 1 clears that pending bit, gated per byte by be.
  - 0x004 ENABLE: read/write, byte-enabled via be.
  - 0x008 CLAIM: read returns ID = lowest index i with pending[i]&enable[i], plus 1; returns 0 if none. The read clears pending[i] in the request cycle. A write returns an error and has no effect.
  - 0x00C STATUS: read-only; bit0 = irq_o, bit1 = |(pending&enable). A write returns an error and has no effect.
  - Any other offset: rdata 0, error 1, no side effects.
  - Bits at index NumSrc and above read 0; writes to them are ignored.
- Source capture:
  - src_q <= src_i every cycle.
  - Edge source: set_i = src_i[i] & ~src_q[i].
  - Level source: set_i = src_i[i].
  - pending_d[i] = set_i | (pending_q[i] & ~clr_i), where clr_i comes from a W1C write or a claim.
  - Set wins over clear in the same cycle. A level source therefore re-pends while it remains high.
- Output: irq_o <= |(pending_q & enable_q). This is a registered output, so there is one cycle from pending/enable to irq_o.
- Bus timing:
  - irq_rvalid_o <= irq_req_i on every request, read or write.
  - rdata and err are captured only when irq_req_i is high, computed from current-cycle state before that cycle's updates.
  - Back-to-back requests are supported, one per cycle.
  - A write updates registers at the clock edge ending the request cycle.
- Claim priority: lowest index wins. The ID computed in a cycle equals the bit cleared in that same cycle.
- Simultaneous events:
  - An edge arriving in the same cycle as its W1C or claim remains pending.
  - An ENABLE write and a CLAIM cannot coincide (one request per cycle).
- Reset mid-operation: all state clears asynchronously; an outstanding response is dropped (irq_rvalid_o = 0).
- Assertions: DataWidth == 32; 1 <= NumSrc <= 31.

Test Plan:
- Reset, then read each register -> PENDING/ENABLE/CLAIM/STATUS read 0; irq_rvalid_o one cycle after each request; irq_err_o = 0.
- NumSrc=8, SrcEdge=0x01: write ENABLE=0x05, pulse src_i[0] for one cycle -> PENDING=0x01; irq_o=1 two cycles after the pulse. CLAIM read returns 1. Next PENDING read returns 0; irq_o drops the cycle after that.
- Hold level src_i[2] high; claim -> returns 3. PENDING bit2 is set again on the following cycle. Drop src_i[2], then W1C 0x04 -> PENDING=0, irq_o=0.
- src_i[1] pending but ENABLE=0x00 -> irq_o stays 0 and CLAIM returns 0. Write ENABLE with be=4'b0001, data 0x02 -> irq_o rises one cycle later.
- Sources 1 and 3 both pending and enabled -> first CLAIM returns 2, second returns 4, third returns 0.
- Error paths: write CLAIM, write STATUS, read 0x010 -> irq_err_o=1, registers unchanged. Rising edge on an edge source in the same cycle as W1C of that bit -> bit remains pending.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt aggregator on the device bus.
// Latches source requests into pending bits, masks them with an enable
// register, raises a registered interrupt line, and offers a claim register
// that returns and clears the lowest-index active source.
module irq_ctrl #(
  parameter int unsigned       DataWidth    = 32,
  parameter int unsigned       AddressWidth = 32,
  parameter int unsigned       NumSrc       = 8,
  parameter logic [NumSrc-1:0] SrcEdge      = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    irq_req_i,
  input  logic [AddressWidth-1:0] irq_addr_i,
  input  logic                    irq_we_i,
  input  logic [DataWidth/8-1:0]  irq_be_i,
  input  logic [DataWidth-1:0]    irq_wdata_i,
  output logic                    irq_rvalid_o,
  output logic [DataWidth-1:0]    irq_rdata_o,
  output logic                    irq_err_o,
  input  logic [NumSrc-1:0]       src_i,
  output logic                    irq_o
);

  localparam logic [9:0] RegPending = 10'h000;
  localparam logic [9:0] RegEnable  = 10'h004;
  localparam logic [9:0] RegClaim   = 10'h008;
  localparam logic [9:0] RegStatus  = 10'h00C;

  logic [9:0]           offset;
  logic [DataWidth-1:0] be_mask;
  logic [NumSrc-1:0]    be_src, wdata_src;
  logic [NumSrc-1:0]    src_q, pending_q, enable_q;
  logic [NumSrc-1:0]    pending_d, enable_d;
  logic [NumSrc-1:0]    active, set, w1c, claim_onehot, clr;
  logic [DataWidth-1:0] claim_id, rdata_d;
  logic                 claim_rd, err_d;
  logic                 unused_bits;

  assign offset      = irq_addr_i[9:0];
  assign unused_bits = ^{irq_addr_i[AddressWidth-1:10],
                         irq_wdata_i[DataWidth-1:NumSrc],
                         be_mask[DataWidth-1:NumSrc]};

  // Expand byte enables into a per-bit write mask.
  always_comb begin
    be_mask = '0;
    for (int unsigned b = 0; b < DataWidth / 8; b++) begin
      be_mask[b*8 +: 8] = {8{irq_be_i[b]}};
    end
  end

  assign be_src    = be_mask[NumSrc-1:0];
  assign wdata_src = irq_wdata_i[NumSrc-1:0];
  assign active    = pending_q & enable_q;
  assign set       = (src_i & ~src_q & SrcEdge) | (src_i & ~SrcEdge);

  // Lowest-index active source: its ID for a claim read and its clear mask.
  always_comb begin
    claim_id     = '0;
    claim_onehot = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (active[i] && (claim_onehot == '0)) begin
        claim_id        = DataWidth'(i + 1);
        claim_onehot[i] = 1'b1;
      end
    end
  end

  // Bus decode: response data, error flag and register side effects.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    w1c      = '0;
    claim_rd = 1'b0;
    enable_d = enable_q;
    if (irq_req_i) begin
      case (offset)
        RegPending: begin
          if (irq_we_i) w1c = be_src & wdata_src;
          else          rdata_d[NumSrc-1:0] = pending_q;
        end
        RegEnable: begin
          if (irq_we_i) enable_d = (enable_q & ~be_src) | (wdata_src & be_src);
          else          rdata_d[NumSrc-1:0] = enable_q;
        end
        RegClaim: begin
          if (irq_we_i) begin
            err_d = 1'b1;
          end else begin
            rdata_d  = claim_id;
            claim_rd = 1'b1;
          end
        end
        RegStatus: begin
          if (irq_we_i) err_d = 1'b1;
          else          rdata_d[1:0] = {|active, irq_o};
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // A new set outranks a clear arriving in the same cycle.
  assign clr       = w1c | (claim_rd ? claim_onehot : '0);
  assign pending_d = set | (pending_q & ~clr);

  // Control state and handshake with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q        <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      irq_o        <= 1'b0;
      irq_rvalid_o <= 1'b0;
    end else begin
      src_q        <= src_i;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      irq_o        <= |active;
      irq_rvalid_o <= irq_req_i;
    end
  end

  // Response payload, captured only on a request.
  // NOTE: rdata/err carry no reset; they are qualified by irq_rvalid_o,
  // which is reset, so leaving the datapath unreset is safe.
  always_ff @(posedge clk_i) begin
    if (irq_req_i) begin
      irq_rdata_o <= rdata_d;
      irq_err_o   <= err_d;
    end
  end

  // Parameter sanity: 32-bit bus and 1..31 sources.
  always_ff @(posedge clk_i) begin
    assert (DataWidth == 32 && NumSrc != 0 && NumSrc <= 31);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, mid-operation
// reset sequence, and randomized traffic against a reference model.
module tb_irq_ctrl;

  localparam int unsigned  NS   = 8;
  localparam logic [NS-1:0] EDGE = 8'h01;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req;
  logic [31:0]   addr;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;
  logic [NS-1:0] src;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(
    .DataWidth(32), .AddressWidth(32), .NumSrc(NS), .SrcEdge(EDGE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .irq_req_i(req), .irq_addr_i(addr), .irq_we_i(we), .irq_be_i(be),
    .irq_wdata_i(wdata), .irq_rvalid_o(rvalid), .irq_rdata_o(rdata),
    .irq_err_o(err), .src_i(src), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  src;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [7:0] s);
    req = r; we = w; addr = a; be = b; wdata = d; src = s;
  endtask

  function automatic vec_t rw(logic r, logic w, logic [9:0] a, logic [3:0] b, logic [31:0] d,
                              logic [7:0] s, logic c, logic [31:0] x, logic e, logic i);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.be = b; v.wdata = d; v.src = s;
    v.chk_rd = c; v.rd = x; v.err = e; v.irq = i;
    return v;
  endfunction

  function automatic vec_t rd_row(logic [9:0] a, logic [7:0] s, logic [31:0] x, logic i);
    return rw(1'b1, 1'b0, a, 4'hF, 32'h0, s, 1'b1, x, 1'b0, i);
  endfunction

  function automatic vec_t wr_row(logic [9:0] a, logic [3:0] b, logic [31:0] d,
                                  logic [7:0] s, logic e, logic i);
    return rw(1'b1, 1'b1, a, b, d, s, 1'b0, 32'h0, e, i);
  endfunction

  function automatic vec_t idle(logic [7:0] s, logic i);
    return rw(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, s, 1'b0, 32'h0, 1'b0, i);
  endfunction

  // Reference model state: pending/enable as bit sets, last source sample.
  logic [7:0]  m_pend, m_en, m_srcq;
  logic        m_irq;
  logic        e_rvalid, e_read, e_err, e_irq;
  logic [31:0] e_rdata;

  // One clock of the model, fed by the currently driven inputs.
  task automatic model_step();
    logic [7:0]  act, clr, setv;
    logic [31:0] id;
    act = m_pend & m_en;
    id  = 32'h0;
    for (int i = 7; i >= 0; i--) if (act[i]) id = 32'(i + 1);
    clr      = 8'h0;
    e_rvalid = req;
    e_read   = req && !we;
    e_err    = 1'b0;
    e_rdata  = 32'h0;
    if (req) begin
      case (addr[9:0])
        10'h000: if (we) clr = be[0] ? wdata[7:0] : 8'h0;
                 else    e_rdata = {24'h0, m_pend};
        10'h004: if (we) begin if (be[0]) m_en = wdata[7:0]; end
                 else    e_rdata = {24'h0, m_en};
        10'h008: if (we) e_err = 1'b1;
                 else begin
                   e_rdata = id;
                   if (id != 0) clr[id-1] = 1'b1;
                 end
        10'h00C: if (we) e_err = 1'b1;
                 else    e_rdata = {30'h0, act != 0, m_irq};
        default: e_err = 1'b1;
      endcase
    end
    setv   = (src & ~EDGE) | (src & ~m_srcq & EDGE);
    e_irq  = (act != 0);
    m_irq  = e_irq;
    m_pend = setv | (m_pend & ~clr);
    m_srcq = src;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0);
    tick();
    check("reset_rvalid", rvalid, 0);
    check("reset_irq", irq, 0);
    tick();
    rst_ni = 1'b1;

    // ---------------- directed vector table ----------------
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h0, 1'b0));
    tbl.push_back(rd_row(10'h004, 8'h00, 32'h0, 1'b0));
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h0, 1'b0));
    tbl.push_back(rd_row(10'h00C, 8'h00, 32'h0, 1'b0));
    tbl.push_back(wr_row(10'h004, 4'hF, 32'h05, 8'h00, 1'b0, 1'b0));   // 4
    tbl.push_back(idle(8'h01, 1'b0));                                    // edge pulse
    tbl.push_back(idle(8'h00, 1'b1));
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h01, 1'b1));
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h01, 1'b1));                // claim 1
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h00, 1'b0));                // 9
    tbl.push_back(idle(8'h04, 1'b0));                                    // level src2
    tbl.push_back(idle(8'h04, 1'b1));
    tbl.push_back(rd_row(10'h008, 8'h04, 32'h03, 1'b1));                // claim 3
    tbl.push_back(rd_row(10'h000, 8'h04, 32'h04, 1'b1));                // re-pended
    tbl.push_back(idle(8'h00, 1'b1));
    tbl.push_back(wr_row(10'h000, 4'hF, 32'h04, 8'h00, 1'b0, 1'b1));   // 15 W1C
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h00, 1'b0));
    tbl.push_back(rd_row(10'h00C, 8'h00, 32'h00, 1'b0));
    tbl.push_back(wr_row(10'h004, 4'hF, 32'h00, 8'h00, 1'b0, 1'b0));   // 18
    tbl.push_back(idle(8'h02, 1'b0));
    tbl.push_back(idle(8'h00, 1'b0));
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h00, 1'b0));                // masked claim
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h02, 1'b0));
    tbl.push_back(wr_row(10'h004, 4'h1, 32'h02, 8'h00, 1'b0, 1'b0));   // 23
    tbl.push_back(rd_row(10'h00C, 8'h00, 32'h02, 1'b1));
    tbl.push_back(rd_row(10'h00C, 8'h00, 32'h03, 1'b1));
    tbl.push_back(wr_row(10'h004, 4'hF, 32'h0A, 8'h00, 1'b0, 1'b1));   // 26
    tbl.push_back(idle(8'h08, 1'b1));
    tbl.push_back(idle(8'h00, 1'b1));
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h02, 1'b1));                // 29
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h04, 1'b1));
    tbl.push_back(rd_row(10'h008, 8'h00, 32'h00, 1'b0));
    tbl.push_back(wr_row(10'h004, 4'hF, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0)); // 32
    tbl.push_back(idle(8'h20, 1'b0));
    tbl.push_back(idle(8'h00, 1'b1));
    tbl.push_back(wr_row(10'h008, 4'hF, 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b1)); // 35
    tbl.push_back(wr_row(10'h00C, 4'hF, 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b1));
    tbl.push_back(rw(1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 8'h00, 1'b1, 32'h0, 1'b1, 1'b1));
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h20, 1'b1));
    tbl.push_back(rd_row(10'h004, 8'h00, 32'hFF, 1'b1));
    tbl.push_back(wr_row(10'h000, 4'hF, 32'h21, 8'h01, 1'b0, 1'b1));   // 40 edge+W1C
    tbl.push_back(rd_row(10'h000, 8'h01, 32'h01, 1'b1));
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h01, 1'b1));
    tbl.push_back(wr_row(10'h000, 4'h2, 32'h01, 8'h00, 1'b0, 1'b1));   // wrong byte
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h01, 1'b1));
    tbl.push_back(wr_row(10'h000, 4'h1, 32'h01, 8'h00, 1'b0, 1'b1));
    tbl.push_back(rd_row(10'h000, 8'h00, 32'h00, 1'b0));
    tbl.push_back(idle(8'h00, 1'b0));

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].we, {22'h0, tbl[i].addr}, tbl[i].be, tbl[i].wdata, tbl[i].src);
      tick();
      check($sformatf("row%0d_rvalid", i), rvalid, tbl[i].req);
      if (tbl[i].req) check($sformatf("row%0d_err", i), err, tbl[i].err);
      if (tbl[i].chk_rd) check($sformatf("row%0d_rdata", i), rdata, tbl[i].rd);
      check($sformatf("row%0d_irq", i), irq, tbl[i].irq);
    end

    // ---------------- reset in the middle of a request stream ----------------
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h10);
    tick();
    tick();
    check("mid_irq_before", irq, 1);
    drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 8'h10);
    tick();
    check("mid_rvalid_before", rvalid, 1);
    check("mid_rdata_before", rdata, 32'h10);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rvalid_async", rvalid, 0);
    check("mid_irq_async", irq, 0);
    tick();
    check("mid_rvalid_held", rvalid, 0);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h00);
    #2;
    rst_ni = 1'b1;
    tick();
    drive(1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 8'h00);
    tick();
    check("post_reset_enable", rdata, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 8'h00);
    tick();
    check("post_reset_pending", rdata, 32'h0);

    // ---------------- randomized traffic vs reference model ----------------
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h00);
    #2;
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    m_pend = 8'h0; m_en = 8'h0; m_srcq = 8'h0; m_irq = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic [9:0] off;
      case ($urandom_range(0, 9))
        0, 1:    off = 10'h000;
        2, 3:    off = 10'h004;
        4, 5, 6: off = 10'h008;
        7:       off = 10'h00C;
        8:       off = 10'h010;
        default: off = 10'($urandom);
      endcase
      req   = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 2) == 0);
      addr  = {22'($urandom), off};
      be    = 4'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 2) == 0) src = 8'($urandom) & 8'($urandom);
      model_step();
      tick();
      check($sformatf("rnd%0d_rvalid", n), rvalid, e_rvalid);
      check($sformatf("rnd%0d_irq", n), irq, e_irq);
      if (e_rvalid) check($sformatf("rnd%0d_err", n), err, e_err);
      if (e_read) check($sformatf("rnd%0d_rdata", n), rdata, e_rdata);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
